// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle CPU phase sequencer: fetch/decode/execute/memory/io/writeback Moore FSM.
// Define SEQ_SINGLE_STEP_EN to add step_mode/step ports and the PAUSED state.
module cpu_phase_sequencer #(
  parameter int unsigned MEM_WAIT_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       core_enable,
  input  logic [2:0] controlMAH,
  input  logic [2:0] controlRB,
  input  logic       allow_write_on_memory,
  input  logic       is_input,
  input  logic       is_output,
  input  logic       io_confirm,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  output logic [2:0] phase,
  output logic       mem_enable,
  output logic       mem_write,
  output logic       ir_load,
  output logic       pc_write,
  output logic       rb_write,
  output logic       io_waiting,
  output logic       halted
);

  // A zero wait count behaves as one; anything above the 4-bit counter range saturates.
  localparam int unsigned MW_EFF = (MEM_WAIT_CYCLES == 0) ? 1 :
                                   ((MEM_WAIT_CYCLES > 15) ? 15 : MEM_WAIT_CYCLES);
  localparam logic [3:0]  LAST_CNT = 4'(MW_EFF - 1);

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    IO_WAIT   = 3'd4,
    WRITEBACK = 3'd5,
    HALTED    = 3'd6,
    PAUSED    = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    IO_WAIT   = 3'd4,
    WRITEBACK = 3'd5,
    HALTED    = 3'd6
  } state_t;
`endif

  typedef struct packed {
    logic mem_enable;
    logic mem_write;
    logic ir_load;
    logic pc_write;
    logic rb_write;
    logic io_waiting;
    logic halted;
  } outs_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       store_q, store_d;
  logic       rb_q, rb_d;
  logic       conf_prev_q;
  logic       confirm_rise;
  outs_t      outs_q;

`ifdef SEQ_SINGLE_STEP_EN
  logic       step_prev_q;
  logic       step_rise;
  assign step_rise = step & ~step_prev_q;
`endif

  assign confirm_rise = io_confirm & ~conf_prev_q;

  // Output decode depends only on state, wait counter and the flags latched in EXECUTE.
  function automatic outs_t decode(input state_t s, input logic [3:0] c,
                                   input logic st, input logic rb);
    outs_t o;
    o = '0;
    case (s)
      FETCH: begin
        o.mem_enable = 1'b1;
        o.ir_load    = (c == LAST_CNT);
      end
      MEMORY: begin
        o.mem_enable = 1'b1;
        o.mem_write  = (c == LAST_CNT) && st;
      end
      IO_WAIT:   o.io_waiting = 1'b1;
      WRITEBACK: begin
        o.pc_write = 1'b1;
        o.rb_write = rb;
      end
      HALTED:    o.halted = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    rb_d    = rb_q;
    case (state_q)
      FETCH:   if (cnt_q == LAST_CNT) state_d = DECODE;
      DECODE:  state_d = EXECUTE;
      EXECUTE: begin
        store_d = allow_write_on_memory;
        rb_d    = |controlRB;
        if (!core_enable)                state_d = HALTED;
        else if (is_input || is_output)  state_d = IO_WAIT;
        else if (|controlMAH)            state_d = MEMORY;
        else                             state_d = WRITEBACK;
      end
      MEMORY:  if (cnt_q == LAST_CNT) state_d = WRITEBACK;
      IO_WAIT: if (confirm_rise) state_d = WRITEBACK;
`ifdef SEQ_SINGLE_STEP_EN
      WRITEBACK: state_d = step_mode ? PAUSED : FETCH;
      PAUSED:    if (step_rise) state_d = FETCH;
`else
      WRITEBACK: state_d = FETCH;
`endif
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase

    // Counter restarts on every state entry and saturates on the last wait cycle.
    if (state_d != state_q)
      cnt_d = 4'd0;
    else if ((state_q == FETCH || state_q == MEMORY) && cnt_q != LAST_CNT)
      cnt_d = cnt_q + 4'd1;
    else
      cnt_d = cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH;
      cnt_q       <= 4'd0;
      store_q     <= 1'b0;
      rb_q        <= 1'b0;
      conf_prev_q <= 1'b1;
      outs_q      <= decode(FETCH, 4'd0, 1'b0, 1'b0);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      rb_q        <= rb_d;
      conf_prev_q <= io_confirm;
      outs_q      <= decode(state_d, cnt_d, store_d, rb_d);
    end
  end

`ifdef SEQ_SINGLE_STEP_EN
  // A step button held through reset must not count as a fresh press.
  always_ff @(posedge clock) begin
    if (reset) step_prev_q <= 1'b1;
    else       step_prev_q <= step;
  end
`endif

  assign phase      = state_q;
  assign mem_enable = outs_q.mem_enable;
  assign mem_write  = outs_q.mem_write;
  assign ir_load    = outs_q.ir_load;
  assign pc_write   = outs_q.pc_write;
  assign rb_write   = outs_q.rb_write;
  assign io_waiting = outs_q.io_waiting;
  assign halted     = outs_q.halted;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed table-driven bench for cpu_phase_sequencer with MEM_WAIT_CYCLES=2.
module tb_cpu_phase_sequencer;

  localparam logic [6:0] E_NONE = 7'b0000000;
  localparam logic [6:0] E_F0   = 7'b1000000;
  localparam logic [6:0] E_F1   = 7'b1010000;
  localparam logic [6:0] E_ME   = 7'b1000000;
  localparam logic [6:0] E_MW   = 7'b1100000;
  localparam logic [6:0] E_WB   = 7'b0001000;
  localparam logic [6:0] E_WBR  = 7'b0001100;
  localparam logic [6:0] E_IO   = 7'b0000010;
  localparam logic [6:0] E_H    = 7'b0000001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       core_enable = 1'b1;
  logic [2:0] controlMAH = 3'd0;
  logic [2:0] controlRB = 3'd0;
  logic       allow_write_on_memory = 1'b0;
  logic       is_input = 1'b0;
  logic       is_output = 1'b0;
  logic       io_confirm = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
`endif
  logic [2:0] phase;
  logic       mem_enable, mem_write, ir_load, pc_write, rb_write, io_waiting, halted;

  cpu_phase_sequencer #(.MEM_WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .core_enable(core_enable),
    .controlMAH(controlMAH), .controlRB(controlRB),
    .allow_write_on_memory(allow_write_on_memory),
    .is_input(is_input), .is_output(is_output), .io_confirm(io_confirm),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .phase(phase), .mem_enable(mem_enable), .mem_write(mem_write),
    .ir_load(ir_load), .pc_write(pc_write), .rb_write(rb_write),
    .io_waiting(io_waiting), .halted(halted)
  );

  // Clock / reset
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       en;
    logic [2:0] mah;
    logic [2:0] rb;
    logic       wr;
    logic       inp;
    logic       outp;
    logic       conf;
    logic [2:0] ph;
    logic [6:0] outs;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] mah, input logic [2:0] rb,
                       input logic wr, input logic inp, input logic outp, input logic conf);
    core_enable = en;
    controlMAH = mah;
    controlRB = rb;
    allow_write_on_memory = wr;
    is_input = inp;
    is_output = outp;
    io_confirm = conf;
  endtask

  task automatic add(input string name, input logic en, input logic [2:0] mah,
                     input logic [2:0] rb, input logic wr, input logic inp, input logic outp,
                     input logic conf, input logic [2:0] ph, input logic [6:0] outs);
    vec_t v;
    v.name = name; v.en = en; v.mah = mah; v.rb = rb; v.wr = wr;
    v.inp = inp; v.outp = outp; v.conf = conf; v.ph = ph; v.outs = outs;
    vecs.push_back(v);
  endtask

  // Scoreboard: expected {phase, outputs} goes through exp_q and is compared against the DUT.
  task automatic check(input string name, input logic [2:0] ph, input logic [6:0] outs);
    logic [9:0] exp_v, act_v;
    exp_q.push_back({ph, outs});
    exp_v = exp_q.pop_front();
    act_v = {phase, mem_enable, mem_write, ir_load, pc_write, rb_write, io_waiting, halted};
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got phase=%0d outs=%b, expected phase=%0d outs=%b",
               name, act_v[9:7], act_v[6:0], exp_v[9:7], exp_v[6:0]);
    end
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    tick();
    check(name, 3'd0, E_F0);
    reset = 1'b0;
  endtask

  initial begin
    // ALU op; junk on decoded inputs outside EXECUTE must be ignored.
    add("alu_f1",  1, 3'd0, 3'd1, 0, 0, 0, 0, 3'd0, E_F1);
    add("alu_dec", 0, 3'd0, 3'd1, 0, 1, 0, 0, 3'd1, E_NONE);
    add("alu_exe", 0, 3'd3, 3'd1, 1, 1, 1, 0, 3'd2, E_NONE);
    add("alu_wb",  1, 3'd0, 3'd1, 0, 0, 0, 0, 3'd5, E_WBR);
    add("alu_f0",  1, 3'd0, 3'd1, 0, 0, 0, 0, 3'd0, E_F0);
    // Store.
    add("st_f1",   1, 3'd5, 3'd0, 1, 0, 0, 0, 3'd0, E_F1);
    add("st_dec",  1, 3'd5, 3'd0, 1, 0, 0, 0, 3'd1, E_NONE);
    add("st_exe",  1, 3'd5, 3'd0, 1, 0, 0, 0, 3'd2, E_NONE);
    add("st_m0",   1, 3'd5, 3'd0, 1, 0, 0, 0, 3'd3, E_ME);
    add("st_m1",   1, 3'd5, 3'd0, 1, 0, 0, 0, 3'd3, E_MW);
    add("st_wb",   1, 3'd5, 3'd0, 1, 0, 0, 0, 3'd5, E_WB);
    add("st_f0",   1, 3'd5, 3'd0, 1, 0, 0, 0, 3'd0, E_F0);
    // Load: memory access without store strobe.
    add("ld_f1",   1, 3'd2, 3'd3, 0, 0, 0, 0, 3'd0, E_F1);
    add("ld_dec",  1, 3'd2, 3'd3, 0, 0, 0, 0, 3'd1, E_NONE);
    add("ld_exe",  1, 3'd2, 3'd3, 0, 0, 0, 0, 3'd2, E_NONE);
    add("ld_m0",   1, 3'd2, 3'd3, 0, 0, 0, 0, 3'd3, E_ME);
    add("ld_m1",   1, 3'd2, 3'd3, 0, 0, 0, 0, 3'd3, E_ME);
    add("ld_wb",   1, 3'd2, 3'd3, 0, 0, 0, 0, 3'd5, E_WBR);
    add("ld_f0",   1, 3'd2, 3'd3, 0, 0, 0, 0, 3'd0, E_F0);
    // Output instruction, confirm rises after two waiting cycles.
    add("out_f1",  1, 3'd0, 3'd0, 0, 0, 1, 0, 3'd0, E_F1);
    add("out_dec", 1, 3'd0, 3'd0, 0, 0, 1, 0, 3'd1, E_NONE);
    add("out_exe", 1, 3'd0, 3'd0, 0, 0, 1, 0, 3'd2, E_NONE);
    add("out_io0", 1, 3'd0, 3'd0, 0, 0, 1, 0, 3'd4, E_IO);
    add("out_io1", 1, 3'd0, 3'd0, 0, 0, 1, 0, 3'd4, E_IO);
    add("out_wb",  1, 3'd0, 3'd0, 0, 0, 1, 1, 3'd5, E_WB);
    add("out_f0",  1, 3'd0, 3'd0, 0, 0, 1, 1, 3'd0, E_F0);
    // Input with MAH set (I/O wins), confirm held high entering IO_WAIT.
    add("in_f1",   1, 3'd1, 3'd2, 0, 1, 0, 1, 3'd0, E_F1);
    add("in_dec",  1, 3'd1, 3'd2, 0, 1, 0, 1, 3'd1, E_NONE);
    add("in_exe",  1, 3'd1, 3'd2, 0, 1, 0, 1, 3'd2, E_NONE);
    add("in_io0",  1, 3'd1, 3'd2, 0, 1, 0, 1, 3'd4, E_IO);
    add("in_hold1",1, 3'd1, 3'd2, 0, 1, 0, 1, 3'd4, E_IO);
    add("in_hold2",1, 3'd1, 3'd2, 0, 1, 0, 1, 3'd4, E_IO);
    add("in_low",  1, 3'd1, 3'd2, 0, 1, 0, 0, 3'd4, E_IO);
    add("in_wb",   1, 3'd1, 3'd2, 0, 1, 0, 1, 3'd5, E_WBR);
    add("in_f0",   1, 3'd1, 3'd2, 0, 1, 0, 1, 3'd0, E_F0);

    drive(1, 3'd0, 3'd0, 0, 0, 0, 0);
    tick();
    do_reset("reset_state");

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].mah, vecs[i].rb, vecs[i].wr,
            vecs[i].inp, vecs[i].outp, vecs[i].conf);
      tick();
      check(vecs[i].name, vecs[i].ph, vecs[i].outs);
    end

    // Halt in EXECUTE, then hold for 100 cycles under random inputs.
    drive(1, 3'd0, 3'd1, 0, 0, 0, 0);
    tick(); check("halt_f1", 3'd0, E_F1);
    tick(); check("halt_dec", 3'd1, E_NONE);
    tick(); check("halt_exe", 3'd2, E_NONE);
    drive(0, 3'd0, 3'd1, 0, 0, 0, 0);
    tick(); check("halt_enter", 3'd6, E_H);
    for (int c = 0; c < 100; c++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      tick();
      check("halt_hold", 3'd6, E_H);
    end
    drive(1, 3'd0, 3'd0, 0, 0, 0, 0);
    do_reset("halt_reset");

    // Reset in the first MEMORY cycle of a store aborts it without a store strobe.
    drive(1, 3'd5, 3'd0, 1, 0, 0, 0);
    tick(); check("abort_f1", 3'd0, E_F1);
    tick(); check("abort_dec", 3'd1, E_NONE);
    tick(); check("abort_exe", 3'd2, E_NONE);
    tick(); check("abort_m0", 3'd3, E_ME);
    do_reset("abort_reset");
    tick(); check("abort_after", 3'd0, E_F1);
    do_reset("abort_reset2");

`ifdef SEQ_SINGLE_STEP_EN
    // Single step: step held high through reset must not release PAUSED.
    step_mode = 1'b1;
    step = 1'b1;
    drive(1, 3'd0, 3'd1, 0, 0, 0, 0);
    do_reset("step_reset");
    tick(); check("step_f1", 3'd0, E_F1);
    tick(); check("step_dec", 3'd1, E_NONE);
    tick(); check("step_exe", 3'd2, E_NONE);
    tick(); check("step_wb", 3'd5, E_WBR);
    tick(); check("step_pause0", 3'd7, E_NONE);
    tick(); check("step_pause1", 3'd7, E_NONE);
    step = 1'b0;
    tick(); check("step_pause2", 3'd7, E_NONE);
    step = 1'b1;
    tick(); check("step_go_f0", 3'd0, E_F0);
    step = 1'b0;
    tick(); check("step2_f1", 3'd0, E_F1);
    tick(); check("step2_dec", 3'd1, E_NONE);
    tick(); check("step2_exe", 3'd2, E_NONE);
    tick(); check("step2_wb", 3'd5, E_WBR);
    tick(); check("step2_pause", 3'd7, E_NONE);
    tick(); check("step2_pause1", 3'd7, E_NONE);
    step_mode = 1'b0;
    step = 1'b1;
    tick(); check("step3_f0", 3'd0, E_F0);
    step = 1'b0;
    tick(); check("step3_f1", 3'd0, E_F1);
    tick(); check("step3_dec", 3'd1, E_NONE);
    tick(); check("step3_exe", 3'd2, E_NONE);
    tick(); check("step3_wb", 3'd5, E_WBR);
    tick(); check("step3_f0b", 3'd0, E_F0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_phase_sequencer.md
CPU_PHASE_SEQUENCER -- requirements
Module: cpu_phase_sequencer

Interface
REQ-001 Parameter: MEM_WAIT_CYCLES, default 2, cycles per memory access (legal 1..15; value 0 SHALL behave as 1).
REQ-002 Ports SHALL be as follows:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- core_enable  input  1  decoded enable; 0 = halt instruction.
- controlMAH  input  3  decoded memory-address mode; non-zero = data memory access.
- controlRB  input  3  decoded register-bank mode; non-zero = register writeback.
- allow_write_on_memory  input  1  decoded store flag.
- is_input, is_output  input  1 each  decoded I/O instruction flags.
- io_confirm  input  1  user confirm level, already synchronized.
- phase  output  3  current state encoding.
- mem_enable  output  1  memory access active.
- mem_write  output  1  data store strobe.
- ir_load  output  1  instruction register load strobe.
- pc_write  output  1  program counter update strobe.
- rb_write  output  1  register bank write strobe.
- io_waiting  output  1  waiting for user confirm.
- halted  output  1  core stopped.

Function
REQ-003 The block SHALL be a Moore FSM; outputs decode only the state register and wait counter.
REQ-004 State encodings on phase SHALL be: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, IO_WAIT=4, WRITEBACK=5, HALTED=6, PAUSED=7.
REQ-005 FETCH behaviour:
- mem_enable=1 for MEM_WAIT_CYCLES cycles (counter 0..MEM_WAIT_CYCLES-1).
- ir_load=1 in the last of those cycles.
- Then DECODE.
REQ-006 DECODE SHALL last one cycle, then EXECUTE.
REQ-007 EXECUTE SHALL last one cycle and exit on its decoded inputs, in priority order:
- core_enable=0 -> HALTED.
- is_input or is_output -> IO_WAIT.
- controlMAH!=0 -> MEMORY.
- Otherwise -> WRITEBACK.
REQ-008 MEMORY behaviour:
- mem_enable=1 for MEM_WAIT_CYCLES cycles.
- mem_write=1 only in the last cycle and only if allow_write_on_memory=1.
- Then WRITEBACK.
REQ-009 IO_WAIT SHALL assert io_waiting=1 and stay until a rising edge of io_confirm (current 1, registered previous 0), then WRITEBACK.
REQ-010 WRITEBACK SHALL last one cycle with pc_write=1 and rb_write=(controlRB!=0), then FETCH.
REQ-011 HALTED SHALL assert halted=1, hold all strobes 0, and leave only on reset.
REQ-012 The wait counter SHALL be 4 bits, clear on every state entry, and never wrap within a state.
REQ-013 Decoded inputs SHALL be sampled only in the states that use them; changes elsewhere SHALL have no effect.
REQ-014 With MEM_WAIT_CYCLES=2, a non-memory, non-I/O instruction SHALL take exactly 5 cycles, FETCH entry to FETCH entry.
REQ-015 Strobes ir_load, pc_write, rb_write and mem_write SHALL each be at most one cycle wide per instruction.

Reset
REQ-016 While reset=1 at a clock edge, the block SHALL:
- set state to FETCH and clear the counter;
- set the io_confirm previous-sample register to 1, so a button held through reset does not confirm.
REQ-017 After reset, outputs SHALL be: phase=0, mem_enable=1, all other outputs 0.
REQ-018 Reset in any state, including HALTED, IO_WAIT or mid-MEMORY, SHALL take priority and abort the instruction with no further strobes.

Configuration
REQ-019 Macro SEQ_SINGLE_STEP_EN SHALL control single-step support.
REQ-020 With SEQ_SINGLE_STEP_EN defined:
- Ports step_mode (input, 1) and step (input, 1, synchronized) SHALL exist.
- WRITEBACK with step_mode=1 SHALL go to PAUSED instead of FETCH.
- PAUSED SHALL hold all strobes 0 until a rising edge of step, then go to FETCH.
- The step previous-sample register SHALL reset to 1.
REQ-021 Without SEQ_SINGLE_STEP_EN, the step ports and the PAUSED state SHALL not exist, and WRITEBACK SHALL always go to FETCH.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- MEM_WAIT_CYCLES=2, ALU op (controlMAH=0, controlRB=1) -> phase 0,0,1,2,5; ir_load in cycle 2; rb_write and pc_write in cycle 5.
- Store (controlMAH=5, allow_write_on_memory=1, controlRB=0) -> MEMORY 2 cycles, mem_write only in the 2nd; rb_write=0 in WRITEBACK.
- is_input=1 with io_confirm held 1 entering IO_WAIT -> stays in IO_WAIT until io_confirm goes 0 then 1; WRITEBACK on the next cycle.
- core_enable=0 in EXECUTE -> halted=1 for 100 cycles with no strobes; reset -> phase=0.
- Reset asserted in MEMORY cycle 1 of a store -> no mem_write; phase=0 next cycle.
- SEQ_SINGLE_STEP_EN defined, step_mode=1 -> PAUSED after WRITEBACK; one step pulse -> exactly one instruction executes, then PAUSED again.
